// File: rtl/nanorv32_uart_ctrl_pkg.sv
// Shared definitions for the nanorv32 UART peripheral: register map,
// STAT/CTRL bit positions, TX/RX state encodings and the CTRL flag group.
// Imported by nanorv32_uart_ctrl; carries no logic of its own.
package nanorv32_uart_ctrl_pkg;

  // Peripheral bus byte-address MSB (addr is PERIPH_ADDR_MSB+1 bits wide).
  localparam int PERIPH_ADDR_MSB = 7;

  // Register select values, taken from addr[3:2].
  localparam logic [1:0] UART_REG_DATA = 2'd0;
  localparam logic [1:0] UART_REG_STAT = 2'd1;
  localparam logic [1:0] UART_REG_CTRL = 2'd2;
  localparam logic [1:0] UART_REG_RSVD = 2'd3;

  // STAT bit positions.
  localparam int STAT_TX_FULL  = 0;
  localparam int STAT_TX_EMPTY = 1;
  localparam int STAT_TX_BUSY  = 2;
  localparam int STAT_RX_VALID = 3;
  localparam int STAT_RX_OVR   = 4;
  localparam int STAT_RX_FERR  = 5;
  localparam int STAT_TX_OVF   = 6;

  // CTRL bit positions.
  localparam int CTRL_DIV_LSB = 0;
  localparam int CTRL_DIV_MSB = 15;
  localparam int CTRL_TX_EN   = 16;
  localparam int CTRL_RX_EN   = 17;
  localparam int CTRL_TXE_IE  = 18;
  localparam int CTRL_RXV_IE  = 19;

  // CTRL[19:16] as one packed group; MSB-first so it maps straight onto the register.
  typedef struct packed {
    logic rxv_ie;
    logic txe_ie;
    logic rx_en;
    logic tx_en;
  } ctrl_flags_t;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/nanorv32_uart_fifo.sv
// Purpose: small synchronous FIFO for the UART TX path (2**AW entries of DW bits).
// Latency: a pushed word is visible on dout the cycle after the push; dout is combinational from storage.
// Backpressure: push is ignored when full unless a pop happens in the same cycle; pop ignored when empty.
// Ports: clk, rst_n (sync, active-low), push/din write side, pop/dout read side, full/empty flags.
module nanorv32_uart_fifo #(
  parameter int DW = 8,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);

  logic [DW-1:0] mem [2**AW];
  // One extra pointer bit distinguishes full from empty when the indices match.
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: the pointers define which entries are meaningful.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/nanorv32_uart_ctrl.sv
// Purpose: memory-mapped 8N1 UART slave (DATA/STAT/CTRL) behind the nanorv32 peripheral mux.
// Latency: zero wait state; side effects in the en cycle, dout registered and valid the next cycle.
// Backpressure: none on the bus; TX pushes into a full FIFO are dropped and flagged in STAT.tx_ovf.
// Ports: clk, rst_n (sync, active-low); bus_uart_addr/bytesel/din/en in, uart_bus_dout/ready_nxt out;
//        uart_pad_tx serial out (idle high), pad_uart_rx serial in (async), uart_irq level interrupt.
// Build option: define NANORV32_UART_RX_EN to include the receiver; without it RX status reads as 0.
module nanorv32_uart_ctrl
  import nanorv32_uart_ctrl_pkg::*;
#(
  parameter int               TXF_AW      = 2,
  parameter int               DIV_W       = 16,
  parameter logic [DIV_W-1:0] DEFAULT_DIV = DIV_W'(433)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [PERIPH_ADDR_MSB:0] bus_uart_addr,
  input  logic [3:0]               bus_uart_bytesel,
  input  logic [31:0]              bus_uart_din,
  input  logic                     bus_uart_en,
  output logic [31:0]              uart_bus_dout,
  output logic                     uart_bus_ready_nxt,
  output logic                     uart_pad_tx,
  input  logic                     pad_uart_rx,
  output logic                     uart_irq
);

  // ---------------------------------------------------------------- bus decode
  logic [1:0]  reg_sel;
  logic        bus_wr;
  logic        bus_rd;
  logic        data_wr;
  logic        data_rd;
  logic        stat_w1c;
  logic        ctrl_wr_en;

  assign reg_sel            = bus_uart_addr[3:2];
  assign bus_wr             = bus_uart_en && (bus_uart_bytesel != 4'd0);
  assign bus_rd             = bus_uart_en && (bus_uart_bytesel == 4'd0);
  assign data_wr            = bus_wr && (reg_sel == UART_REG_DATA);
  assign data_rd            = bus_rd && (reg_sel == UART_REG_DATA);
  assign stat_w1c           = bus_wr && (reg_sel == UART_REG_STAT) && bus_uart_bytesel[0];
  assign ctrl_wr_en         = bus_wr && (reg_sel == UART_REG_CTRL);
  assign uart_bus_ready_nxt = bus_uart_en;

  // ---------------------------------------------------------------- CTRL
  logic [DIV_W-1:0] div_q;
  ctrl_flags_t      flags;
  logic [31:0]      ctrl_rd;
  logic [31:0]      ctrl_wr;

  assign ctrl_rd = {12'd0, flags, 16'(div_q)};

  // Per-lane merge of write data over the current register value.
  always_comb begin
    ctrl_wr = ctrl_rd;
    for (int i = 0; i < 4; i++) begin
      if (bus_uart_bytesel[i]) ctrl_wr[8*i +: 8] = bus_uart_din[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q <= DEFAULT_DIV;
      flags <= '0;
    end else if (ctrl_wr_en) begin
      div_q <= ctrl_wr[CTRL_DIV_LSB +: DIV_W];
      flags <= ctrl_wr[CTRL_RXV_IE:CTRL_TX_EN];
    end
  end

  // ---------------------------------------------------------------- TX FIFO
  logic       tx_pop;
  logic [7:0] txf_dout;
  logic       txf_full;
  logic       txf_empty;
  logic       tx_ovf;

  nanorv32_uart_fifo #(
    .DW (8),
    .AW (TXF_AW)
  ) u_txf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (data_wr),
    .pop   (tx_pop),
    .din   (bus_uart_din[7:0]),
    .dout  (txf_dout),
    .full  (txf_full),
    .empty (txf_empty)
  );

  // Sticky overflow: a set in the same cycle as a W1C wins so no drop goes unreported.
  always_ff @(posedge clk) begin
    if (!rst_n)                                      tx_ovf <= 1'b0;
    else if (data_wr && txf_full && !tx_pop)         tx_ovf <= 1'b1;
    else if (stat_w1c && bus_uart_din[STAT_TX_OVF])  tx_ovf <= 1'b0;
  end

  // ---------------------------------------------------------------- TX FSM
  tx_state_t        tx_state;
  tx_state_t        tx_state_nxt;
  logic [DIV_W-1:0] tx_cnt;
  logic [2:0]       tx_bit;
  logic [7:0]       tx_shift;
  logic             tx_pad;
  logic             tx_pad_nxt;
  logic             tx_bit_end;
  logic             tx_go;
  logic             tx_reload;
  logic             tx_shift_en;
  logic             tx_busy;

  assign tx_bit_end  = (tx_cnt == '0);
  assign tx_go       = !txf_empty && flags.tx_en;
  assign tx_busy     = (tx_state != TX_IDLE);
  assign uart_pad_tx = tx_pad;

  always_ff @(posedge clk) begin
    if (!rst_n) tx_state <= TX_IDLE;
    else        tx_state <= tx_state_nxt;
  end

  // STOP chains straight into START when more data is ready, so frames abut.
  always_comb begin
    tx_state_nxt = tx_state;
    case (tx_state)
      TX_IDLE:  if (tx_go) tx_state_nxt = TX_START;
      TX_START: if (tx_bit_end) tx_state_nxt = TX_DATA;
      TX_DATA:  if (tx_bit_end && (tx_bit == 3'd7)) tx_state_nxt = TX_STOP;
      TX_STOP:  if (tx_bit_end) tx_state_nxt = tx_go ? TX_START : TX_IDLE;
      default:  tx_state_nxt = TX_IDLE;
    endcase
  end

  // The pad is registered, so each bit value is staged one cycle ahead as tx_pad_nxt.
  always_comb begin
    tx_pop      = 1'b0;
    tx_reload   = 1'b0;
    tx_shift_en = 1'b0;
    tx_pad_nxt  = tx_pad;
    case (tx_state)
      TX_IDLE: begin
        tx_pad_nxt = 1'b1;
        if (tx_go) begin
          tx_pop     = 1'b1;
          tx_reload  = 1'b1;
          tx_pad_nxt = 1'b0;
        end
      end
      TX_START: begin
        if (tx_bit_end) begin
          tx_reload  = 1'b1;
          tx_pad_nxt = tx_shift[0];
        end
      end
      TX_DATA: begin
        if (tx_bit_end) begin
          tx_reload   = 1'b1;
          tx_shift_en = 1'b1;
          tx_pad_nxt  = (tx_bit == 3'd7) ? 1'b1 : tx_shift[1];
        end
      end
      TX_STOP: begin
        if (tx_bit_end) begin
          if (tx_go) begin
            tx_pop     = 1'b1;
            tx_reload  = 1'b1;
            tx_pad_nxt = 1'b0;
          end else begin
            tx_pad_nxt = 1'b1;
          end
        end
      end
      default: tx_pad_nxt = 1'b1;
    endcase
  end

  // Baud counter reloads from the live divisor, so a div change applies at the next bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_pad   <= 1'b1;
    end else begin
      tx_pad <= tx_pad_nxt;
      if (tx_reload)        tx_cnt <= div_q;
      else if (!tx_bit_end) tx_cnt <= tx_cnt - DIV_W'(1);
      if (tx_pop) begin
        tx_shift <= txf_dout;
        tx_bit   <= '0;
      end else if (tx_shift_en) begin
        tx_shift <= {1'b0, tx_shift[7:1]};
        tx_bit   <= tx_bit + 3'd1;
      end
    end
  end

  // ---------------------------------------------------------------- RX
  logic       rx_valid;
  logic       rx_ovr;
  logic       rx_ferr;
  logic [7:0] rx_byte;
  logic       unused_bits;

`ifdef NANORV32_UART_RX_EN
  logic             rx_s1;
  logic             rx_s2;
  rx_state_t        rx_state;
  rx_state_t        rx_state_nxt;
  logic [DIV_W-1:0] rx_cnt;
  logic [2:0]       rx_bit;
  logic [7:0]       rx_shift;
  logic             rx_cnt_zero;
  logic             rx_arm;
  logic             rx_reload;
  logic             rx_sample;
  logic             rx_good;
  logic             rx_bad;
  logic             rx_load;

  assign rx_cnt_zero = (rx_cnt == '0);
  // A good byte is kept if the buffer is free, or is being read out this very cycle.
  assign rx_load     = rx_good && (!rx_valid || data_rd);

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= pad_uart_rx;
      rx_s2 <= rx_s1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) rx_state <= RX_IDLE;
    else        rx_state <= rx_state_nxt;
  end

  always_comb begin
    rx_state_nxt = rx_state;
    if (!flags.rx_en) begin
      rx_state_nxt = RX_IDLE;
    end else begin
      case (rx_state)
        RX_IDLE:  if (!rx_s2) rx_state_nxt = RX_START;
        // Mid-start recheck: a line back high means it was a glitch.
        RX_START: if (rx_cnt_zero) rx_state_nxt = rx_s2 ? RX_IDLE : RX_DATA;
        RX_DATA:  if (rx_cnt_zero && (rx_bit == 3'd7)) rx_state_nxt = RX_STOP;
        RX_STOP:  if (rx_cnt_zero) rx_state_nxt = RX_IDLE;
        default:  rx_state_nxt = RX_IDLE;
      endcase
    end
  end

  always_comb begin
    rx_arm    = 1'b0;
    rx_reload = 1'b0;
    rx_sample = 1'b0;
    rx_good   = 1'b0;
    rx_bad    = 1'b0;
    if (flags.rx_en) begin
      case (rx_state)
        RX_IDLE:  rx_arm = !rx_s2;
        RX_START: rx_reload = rx_cnt_zero && !rx_s2;
        RX_DATA: begin
          rx_sample = rx_cnt_zero;
          rx_reload = rx_cnt_zero;
        end
        RX_STOP: begin
          rx_good = rx_cnt_zero && rx_s2;
          rx_bad  = rx_cnt_zero && !rx_s2;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_byte  <= '0;
      rx_valid <= 1'b0;
      rx_ovr   <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      // Half-bit wait on the start edge puts later samples near mid-bit.
      if (rx_arm)            rx_cnt <= div_q >> 1;
      else if (rx_reload)    rx_cnt <= div_q;
      else if (!rx_cnt_zero) rx_cnt <= rx_cnt - DIV_W'(1);

      if (rx_arm) begin
        rx_bit <= '0;
      end else if (rx_sample) begin
        rx_bit   <= rx_bit + 3'd1;
        rx_shift <= {rx_s2, rx_shift[7:1]};
      end

      if (rx_load) rx_byte <= rx_shift;

      if (rx_load)      rx_valid <= 1'b1;
      else if (data_rd) rx_valid <= 1'b0;

      if (rx_good && !rx_load)                          rx_ovr <= 1'b1;
      else if (stat_w1c && bus_uart_din[STAT_RX_OVR])   rx_ovr <= 1'b0;

      if (rx_bad)                                       rx_ferr <= 1'b1;
      else if (stat_w1c && bus_uart_din[STAT_RX_FERR])  rx_ferr <= 1'b0;
    end
  end

  assign unused_bits = ^{bus_uart_addr[PERIPH_ADDR_MSB:4], bus_uart_addr[1:0], ctrl_wr[31:20]};
`else
  assign rx_valid    = 1'b0;
  assign rx_ovr      = 1'b0;
  assign rx_ferr     = 1'b0;
  assign rx_byte     = 8'd0;
  assign unused_bits = ^{bus_uart_addr[PERIPH_ADDR_MSB:4], bus_uart_addr[1:0], ctrl_wr[31:20],
                         pad_uart_rx, data_rd};
`endif

  // ---------------------------------------------------------------- read path / irq
  logic [31:0] stat_rd;
  logic [31:0] rd_data;

  always_comb begin
    stat_rd                = '0;
    stat_rd[STAT_TX_FULL]  = txf_full;
    stat_rd[STAT_TX_EMPTY] = txf_empty;
    stat_rd[STAT_TX_BUSY]  = tx_busy;
    stat_rd[STAT_RX_VALID] = rx_valid;
    stat_rd[STAT_RX_OVR]   = rx_ovr;
    stat_rd[STAT_RX_FERR]  = rx_ferr;
    stat_rd[STAT_TX_OVF]   = tx_ovf;
  end

  always_comb begin
    rd_data = '0;
    case (reg_sel)
      UART_REG_DATA: rd_data = {24'd0, rx_byte};
      UART_REG_STAT: rd_data = stat_rd;
      UART_REG_CTRL: rd_data = ctrl_rd;
      UART_REG_RSVD: rd_data = '0;
      default:       rd_data = '0;
    endcase
  end

  // Read data reflects state before this cycle's side effects; held between reads.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      uart_bus_dout <= '0;
      uart_irq      <= 1'b0;
    end else begin
      if (bus_rd) uart_bus_dout <= rd_data;
      uart_irq <= (flags.txe_ie && txf_empty && !tx_busy) || (flags.rxv_ie && rx_valid);
    end
  end

endmodule

// File: tb/tb_nanorv32_uart_ctrl.sv
// Directed bench for nanorv32_uart_ctrl: register reset values, lane writes,
// TX frame shape and timing, FIFO overflow, interrupt lag, mid-frame reset,
// and (with NANORV32_UART_RX_EN) receive, glitch reject, overrun and framing error.
module tb_nanorv32_uart_ctrl;
  import nanorv32_uart_ctrl_pkg::*;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [PERIPH_ADDR_MSB:0] addr;
  logic [3:0]               bytesel;
  logic [31:0]              din;
  logic                     en;
  logic [31:0]              dout;
  logic                     ready_nxt;
  logic                     tx;
  logic                     rx;
  logic                     irq;

  int checks = 0;
  int errors = 0;

  nanorv32_uart_ctrl dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .bus_uart_addr      (addr),
    .bus_uart_bytesel   (bytesel),
    .bus_uart_din       (din),
    .bus_uart_en        (en),
    .uart_bus_dout      (dout),
    .uart_bus_ready_nxt (ready_nxt),
    .uart_pad_tx        (tx),
    .pad_uart_rx        (rx),
    .uart_irq           (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want);
    end
  endtask

  // All tasks enter and leave 1 time unit after a rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [3:0] bs, input logic [31:0] d);
    addr      = '0;
    addr[3:0] = a;
    bytesel   = bs;
    din       = d;
    en        = 1'b1;
    tick(1);
    en        = 1'b0;
    bytesel   = 4'd0;
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] a, input logic [31:0] want);
    addr      = '0;
    addr[3:0] = a;
    bytesel   = 4'd0;
    en        = 1'b1;
    tick(1);
    en        = 1'b0;
    chk(tag, 64'(dout), 64'(want));
  endtask

  // Expects a div=3 frame (4 clocks per bit) to start on the very next clock.
  task automatic check_frame(input string tag, input logic [7:0] b);
    int          lat;
    logic [39:0] obs;
    logic [39:0] want;
    lat = 0;
    obs = '0;
    while (tx !== 1'b0 && lat < 500) begin
      tick(1);
      lat++;
    end
    obs[0] = tx;
    for (int i = 1; i < 40; i++) begin
      tick(1);
      obs[i] = tx;
    end
    for (int i = 0; i < 40; i++) begin
      if (i < 4)        want[i] = 1'b0;
      else if (i >= 36) want[i] = 1'b1;
      else              want[i] = b[(i - 4) / 4];
    end
    chk({tag, "_lat"}, 64'(lat), 64'd1);
    chk({tag, "_bits"}, 64'(obs), 64'(want));
  endtask

`ifdef NANORV32_UART_RX_EN
  task automatic rx_frame(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      tick(4);
    end
    rx = 1'b1;
  endtask
`endif

  initial begin
    rst_n   = 1'b0;
    en      = 1'b0;
    bytesel = 4'd0;
    din     = '0;
    addr    = '0;
    rx      = 1'b1;
    tick(3);
    chk("rst_dout", 64'(dout), 64'd0);
    chk("rst_tx", 64'(tx), 64'd1);
    chk("rst_irq", 64'(irq), 64'd0);
    rst_n = 1'b1;
    tick(1);

    rd_chk("ctrl_reset", 4'h8, 32'h0000_01B1);
    rd_chk("stat_reset", 4'h4, 32'h0000_0002);

    // Byte-lane writes to CTRL.
    bus_write(4'h8, 4'b0001, 32'hFFFF_FF07);
    rd_chk("ctrl_lane0", 4'h8, 32'h0000_0107);
    bus_write(4'h8, 4'b0100, 32'h000F_0000);
    rd_chk("ctrl_lane2", 4'h8, 32'h000F_0107);
    bus_write(4'h8, 4'b1111, 32'h0001_0003);
    rd_chk("ctrl_full", 4'h8, 32'h0001_0003);

    // Reserved register: writes ignored, reads zero, zero wait state.
    bus_write(4'hC, 4'b1111, 32'hFFFF_FFFF);
    addr      = '0;
    addr[3:0] = 4'hC;
    bytesel   = 4'd0;
    en        = 1'b1;
    #1;
    chk("ready_nxt", 64'(ready_nxt), 64'd1);
    tick(1);
    en = 1'b0;
    chk("rsvd_read", 64'(dout), 64'd0);

`ifndef NANORV32_UART_RX_EN
    rd_chk("data_read_norx", 4'h0, 32'h0);
`endif

    // Single frame 0xA5 at div=3.
    bus_write(4'h0, 4'b0001, 32'h0000_00A5);
    check_frame("a5", 8'hA5);
    tick(2);
    rd_chk("stat_after_a5", 4'h4, 32'h0000_0002);

    // Overflow with TX disabled, then four back-to-back frames.
    bus_write(4'h8, 4'b1111, 32'h0000_0003);
    bus_write(4'h0, 4'b0001, 32'h11);
    bus_write(4'h0, 4'b0001, 32'h22);
    bus_write(4'h0, 4'b0001, 32'h33);
    bus_write(4'h0, 4'b0001, 32'h44);
    bus_write(4'h0, 4'b0001, 32'h55);
    rd_chk("stat_ovf", 4'h4, 32'h0000_0041);
    bus_write(4'h4, 4'b0001, 32'h0000_0040);
    rd_chk("stat_ovf_w1c", 4'h4, 32'h0000_0001);
    bus_write(4'h8, 4'b1111, 32'h0001_0003);
    check_frame("q0", 8'h11);
    check_frame("q1", 8'h22);
    check_frame("q2", 8'h33);
    check_frame("q3", 8'h44);
    tick(2);
    rd_chk("stat_drained", 4'h4, 32'h0000_0002);
    chk("tx_idle_drained", 64'(tx), 64'd1);

`ifdef NANORV32_UART_RX_EN
    // Receive path at div=3 with rxv_ie set.
    bus_write(4'h8, 4'b1111, 32'h000A_0003);
    rx_frame(8'h3C, 1'b1);
    tick(6);
    rd_chk("rx_stat_valid", 4'h4, 32'h0000_000A);
    chk("rx_irq", 64'(irq), 64'd1);
    rd_chk("rx_data_3c", 4'h0, 32'h0000_003C);
    rd_chk("rx_stat_clear", 4'h4, 32'h0000_0002);

    rx = 1'b0;
    tick(2);
    rx = 1'b1;
    tick(20);
    rd_chk("rx_glitch", 4'h4, 32'h0000_0002);

    rx_frame(8'h5A, 1'b1);
    tick(6);
    rd_chk("rx_stat_5a", 4'h4, 32'h0000_000A);
    rx_frame(8'hC3, 1'b1);
    tick(6);
    rd_chk("rx_stat_ovr", 4'h4, 32'h0000_001A);
    rd_chk("rx_data_kept", 4'h0, 32'h0000_005A);
    rd_chk("rx_stat_ovr2", 4'h4, 32'h0000_0012);
    bus_write(4'h4, 4'b0001, 32'h0000_0010);
    rd_chk("rx_ovr_w1c", 4'h4, 32'h0000_0002);

    rx_frame(8'h77, 1'b0);
    tick(10);
    rd_chk("rx_ferr", 4'h4, 32'h0000_0022);
    bus_write(4'h4, 4'b0001, 32'h0000_0020);
    rd_chk("rx_ferr_w1c", 4'h4, 32'h0000_0002);
`endif

    // TX-empty interrupt: registered, so it trails the enabling write by a cycle.
    bus_write(4'h8, 4'b1111, 32'h0005_0003);
    chk("irq_lag", 64'(irq), 64'd0);
    tick(1);
    chk("irq_txe", 64'(irq), 64'd1);
    bus_write(4'h0, 4'b0001, 32'h81);
    bus_write(4'h0, 4'b0001, 32'h82);
    chk("irq_busy", 64'(irq), 64'd0);
    chk("tx_midframe", 64'(tx), 64'd0);
    rd_chk("stat_midframe", 4'h4, 32'h0000_0004);

    // Reset in the middle of a frame.
    tick(5);
    rst_n = 1'b0;
    tick(1);
    chk("rst_mid_tx", 64'(tx), 64'd1);
    chk("rst_mid_irq", 64'(irq), 64'd0);
    chk("rst_mid_dout", 64'(dout), 64'd0);
    rst_n = 1'b1;
    tick(1);
    rd_chk("rst_mid_ctrl", 4'h8, 32'h0000_01B1);
    rd_chk("rst_mid_stat", 4'h4, 32'h0000_0002);
    tick(50);
    chk("rst_mid_tx_idle", 64'(tx), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
